// File: rtl/vga_arbiter_pkg.sv
// Shared definitions for the VGA arbiter: client flag encoding, default data
// width and the response-side beat classification.
package vga_arbiter_pkg;

    localparam logic VGA_ARB_FLAG_DISP = 1'b0;
    localparam logic VGA_ARB_FLAG_BUS  = 1'b1;
    localparam int   VGA_ARB_DW        = 32;

    typedef enum logic [1:0] {
        BEAT_IDLE,
        BEAT_ORPHAN,
        BEAT_STALE,
        BEAT_ROUTE
    } beat_class_e;

    // A flush on the beat cycle makes the head tag stale even if it still reads valid.
    function automatic beat_class_e classify_beat(input logic mem_valid,
                                                  input logic q_empty,
                                                  input logic q_valid,
                                                  input logic flush);
        beat_class_e cls;
        if (!mem_valid)
            cls = BEAT_IDLE;
        else if (q_empty)
            cls = BEAT_ORPHAN;
        else if (!q_valid || flush)
            cls = BEAT_STALE;
        else
            cls = BEAT_ROUTE;
        return cls;
    endfunction

endpackage

// File: rtl/vga_arbiter_response_slot.sv
// One-entry output slot for a read-data client: holds a beat until the
// client is no longer busy. Free when empty or being drained this cycle.
module vga_arbiter_response_slot #(
    parameter int DW = 32
) (
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          sync_reset,
    input  logic          flush,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          busy,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          free
);

    assign free = !valid || !busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)
            valid <= 1'b0;
        else if (sync_reset || flush)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (!busy)
            valid <= 1'b0;
    end

    // NOTE: the data register is deliberately not reset; valid alone qualifies it.
    always_ff @(posedge iCLOCK) begin
        if (load)
            data <= load_data;
    end

endmodule

// File: rtl/vga_arbiter_response_router.sv
// Read side of the arbiter's tag matching queue: pops one tag per SDRAM
// read beat and steers the beat to the display or CPU bus slot.
module vga_arbiter_response_router
    import vga_arbiter_pkg::*;
#(
    parameter int DW = VGA_ARB_DW,
    parameter int FN = 1,
    parameter int CW = 8
) (
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          iRESET_SYNC,
    input  logic          iFLASH,
    output logic          oQ_RD_REQ,
    input  logic          iQ_RD_VALID,
    input  logic [FN-1:0] iQ_RD_FLAG,
    input  logic          iQ_RD_EMPTY,
    input  logic          iMEM_VALID,
    input  logic [DW-1:0] iMEM_DATA,
    output logic          oMEM_BUSY,
    output logic          oDISP_VALID,
    output logic [DW-1:0] oDISP_DATA,
    input  logic          iDISP_BUSY,
    output logic          oBUS_VALID,
    output logic [DW-1:0] oBUS_DATA,
    input  logic          iBUS_BUSY,
    output logic          oERR_ORPHAN,
    output logic [CW-1:0] oDISCARD_CNT
);

    beat_class_e beat_class;
    logic        target;
    logic        target_free;
    logic        disp_free;
    logic        bus_free;
    logic        active;
    logic        accept;
    logic        load_disp;
    logic        load_bus;

    assign target = iQ_RD_FLAG[0];
    assign active = inRESET && !iRESET_SYNC;

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        beat_class  = classify_beat(iMEM_VALID, iQ_RD_EMPTY, iQ_RD_VALID, iFLASH);
        target_free = disp_free;
        if (target == VGA_ARB_FLAG_BUS)
            target_free = bus_free;
    end

    // Only a routable beat can stall; stale and orphan beats are always swallowed.
    assign oMEM_BUSY = (beat_class == BEAT_ROUTE) && !target_free;
    assign accept    = active && iMEM_VALID && !oMEM_BUSY;
    assign oQ_RD_REQ = accept && !iQ_RD_EMPTY;
    assign load_disp = accept && (beat_class == BEAT_ROUTE) && (target == VGA_ARB_FLAG_DISP);
    assign load_bus  = accept && (beat_class == BEAT_ROUTE) && (target == VGA_ARB_FLAG_BUS);

    vga_arbiter_response_slot #(.DW(DW)) u_disp_slot (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .sync_reset (iRESET_SYNC),
        .flush      (iFLASH),
        .load       (load_disp),
        .load_data  (iMEM_DATA),
        .busy       (iDISP_BUSY),
        .valid      (oDISP_VALID),
        .data       (oDISP_DATA),
        .free       (disp_free)
    );

    vga_arbiter_response_slot #(.DW(DW)) u_bus_slot (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .sync_reset (iRESET_SYNC),
        .flush      (iFLASH),
        .load       (load_bus),
        .load_data  (iMEM_DATA),
        .busy       (iBUS_BUSY),
        .valid      (oBUS_VALID),
        .data       (oBUS_DATA),
        .free       (bus_free)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oERR_ORPHAN  <= 1'b0;
            oDISCARD_CNT <= '0;
        end else if (iRESET_SYNC) begin
            oERR_ORPHAN  <= 1'b0;
            oDISCARD_CNT <= '0;
        end else begin
            if (beat_class == BEAT_ORPHAN)
                oERR_ORPHAN <= 1'b1;
            if (accept && (beat_class == BEAT_STALE) && (oDISCARD_CNT != '1))
                oDISCARD_CNT <= oDISCARD_CNT + CW'(1);
        end
    end

endmodule

// File: tb/tb_vga_arbiter_response_router.sv
// Directed bench for vga_arbiter_response_router: routing, backpressure,
// flush draining, orphan detection, counter saturation and async reset.
module tb_vga_arbiter_response_router;

    localparam int DW = 32;
    localparam int FN = 1;
    localparam int CW = 8;

    logic          iCLOCK;
    logic          inRESET;
    logic          iRESET_SYNC;
    logic          iFLASH;
    logic          oQ_RD_REQ;
    logic          iQ_RD_VALID;
    logic [FN-1:0] iQ_RD_FLAG;
    logic          iQ_RD_EMPTY;
    logic          iMEM_VALID;
    logic [DW-1:0] iMEM_DATA;
    logic          oMEM_BUSY;
    logic          oDISP_VALID;
    logic [DW-1:0] oDISP_DATA;
    logic          iDISP_BUSY;
    logic          oBUS_VALID;
    logic [DW-1:0] oBUS_DATA;
    logic          iBUS_BUSY;
    logic          oERR_ORPHAN;
    logic [CW-1:0] oDISCARD_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    vga_arbiter_response_router #(.DW(DW), .FN(FN), .CW(CW)) dut (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .iRESET_SYNC  (iRESET_SYNC),
        .iFLASH       (iFLASH),
        .oQ_RD_REQ    (oQ_RD_REQ),
        .iQ_RD_VALID  (iQ_RD_VALID),
        .iQ_RD_FLAG   (iQ_RD_FLAG),
        .iQ_RD_EMPTY  (iQ_RD_EMPTY),
        .iMEM_VALID   (iMEM_VALID),
        .iMEM_DATA    (iMEM_DATA),
        .oMEM_BUSY    (oMEM_BUSY),
        .oDISP_VALID  (oDISP_VALID),
        .oDISP_DATA   (oDISP_DATA),
        .iDISP_BUSY   (iDISP_BUSY),
        .oBUS_VALID   (oBUS_VALID),
        .oBUS_DATA    (oBUS_DATA),
        .iBUS_BUSY    (iBUS_BUSY),
        .oERR_ORPHAN  (oERR_ORPHAN),
        .oDISCARD_CNT (oDISCARD_CNT)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    // Present one read beat with the given head-of-queue state.
    task automatic beat(input logic empty, input logic qvalid, input logic flag, input logic [DW-1:0] data);
        iMEM_VALID  = 1'b1;
        iQ_RD_EMPTY = empty;
        iQ_RD_VALID = qvalid;
        iQ_RD_FLAG  = flag;
        iMEM_DATA   = data;
        #1;
    endtask

    task automatic idle();
        iMEM_VALID  = 1'b0;
        iQ_RD_EMPTY = 1'b1;
        iQ_RD_VALID = 1'b0;
        iQ_RD_FLAG  = '0;
        iMEM_DATA   = '0;
        #1;
    endtask

    initial begin
        inRESET     = 1'b0;
        iRESET_SYNC = 1'b0;
        iFLASH      = 1'b0;
        iDISP_BUSY  = 1'b0;
        iBUS_BUSY   = 1'b0;
        idle();
        tick();
        tick();
        check("rst_disp_valid", oDISP_VALID, 1'b0);
        check("rst_bus_valid", oBUS_VALID, 1'b0);
        check("rst_orphan", oERR_ORPHAN, 1'b0);
        check("rst_cnt", oDISCARD_CNT, 8'd0);
        inRESET = 1'b1;
        tick();

        // 1: tags 0,1,0 with both clients idle
        beat(1'b0, 1'b1, 1'b0, 32'hAAAA_0001);
        check("t1_pop_a", oQ_RD_REQ, 1'b1);
        check("t1_busy_a", oMEM_BUSY, 1'b0);
        tick();
        beat(1'b0, 1'b1, 1'b1, 32'hBBBB_0002);
        check("t1_disp_valid_a", oDISP_VALID, 1'b1);
        check("t1_disp_data_a", oDISP_DATA, 32'hAAAA_0001);
        check("t1_pop_b", oQ_RD_REQ, 1'b1);
        check("t1_busy_b", oMEM_BUSY, 1'b0);
        tick();
        beat(1'b0, 1'b1, 1'b0, 32'hCCCC_0003);
        check("t1_bus_valid_b", oBUS_VALID, 1'b1);
        check("t1_bus_data_b", oBUS_DATA, 32'hBBBB_0002);
        check("t1_disp_drained", oDISP_VALID, 1'b0);
        check("t1_pop_c", oQ_RD_REQ, 1'b1);
        check("t1_busy_c", oMEM_BUSY, 1'b0);
        tick();
        idle();
        check("t1_disp_valid_c", oDISP_VALID, 1'b1);
        check("t1_disp_data_c", oDISP_DATA, 32'hCCCC_0003);
        check("t1_bus_drained", oBUS_VALID, 1'b0);
        check("t1_no_pop_idle", oQ_RD_REQ, 1'b0);
        tick();
        check("t1_disp_empty", oDISP_VALID, 1'b0);

        // 2: display busy stalls the second beat
        iDISP_BUSY = 1'b1;
        beat(1'b0, 1'b1, 1'b0, 32'h0000_00A1);
        check("t2_pop_a", oQ_RD_REQ, 1'b1);
        tick();
        beat(1'b0, 1'b1, 1'b0, 32'h0000_00B2);
        check("t2_disp_valid_a", oDISP_VALID, 1'b1);
        check("t2_stall_busy", oMEM_BUSY, 1'b1);
        check("t2_stall_no_pop", oQ_RD_REQ, 1'b0);
        tick();
        check("t2_hold_data", oDISP_DATA, 32'h0000_00A1);
        check("t2_still_busy", oMEM_BUSY, 1'b1);
        iDISP_BUSY = 1'b0;
        #1;
        check("t2_release_busy", oMEM_BUSY, 1'b0);
        check("t2_release_pop", oQ_RD_REQ, 1'b1);
        tick();
        idle();
        check("t2_disp_valid_b", oDISP_VALID, 1'b1);
        check("t2_disp_data_b", oDISP_DATA, 32'h0000_00B2);
        tick();
        check("t2_disp_empty", oDISP_VALID, 1'b0);

        // 3: flush clears a held slot, flushed tags drain and count
        iBUS_BUSY = 1'b1;
        beat(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        tick();
        iFLASH = 1'b1;
        beat(1'b0, 1'b1, 1'b1, 32'h0BAD_0001);
        check("t3_bus_held", oBUS_VALID, 1'b1);
        check("t3_flash_beat_busy", oMEM_BUSY, 1'b0);
        check("t3_flash_beat_pop", oQ_RD_REQ, 1'b1);
        tick();
        iFLASH = 1'b0;
        beat(1'b0, 1'b0, 1'b0, 32'h0BAD_0002);
        check("t3_bus_flushed", oBUS_VALID, 1'b0);
        check("t3_cnt1", oDISCARD_CNT, 8'd1);
        check("t3_stale_pop", oQ_RD_REQ, 1'b1);
        check("t3_stale_busy", oMEM_BUSY, 1'b0);
        tick();
        beat(1'b0, 1'b0, 1'b1, 32'h0BAD_0003);
        check("t3_stale_pop2", oQ_RD_REQ, 1'b1);
        tick();
        idle();
        iBUS_BUSY = 1'b0;
        check("t3_cnt3", oDISCARD_CNT, 8'd3);
        check("t3_no_disp", oDISP_VALID, 1'b0);
        check("t3_no_bus", oBUS_VALID, 1'b0);

        // 4: orphan beat sets a sticky error cleared only by reset
        beat(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("t4_no_pop", oQ_RD_REQ, 1'b0);
        check("t4_no_busy", oMEM_BUSY, 1'b0);
        tick();
        idle();
        check("t4_orphan_set", oERR_ORPHAN, 1'b1);
        check("t4_no_load", oDISP_VALID, 1'b0);
        tick();
        tick();
        check("t4_orphan_held", oERR_ORPHAN, 1'b1);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        check("t4_orphan_cleared", oERR_ORPHAN, 1'b0);
        check("t4_cnt_cleared", oDISCARD_CNT, 8'd0);

        // 5: 300 stale beats saturate the discard counter
        beat(1'b0, 1'b0, 1'b0, 32'h5A5A_5A5A);
        repeat (100) tick();
        check("t5_cnt100", oDISCARD_CNT, 8'd100);
        repeat (200) tick();
        check("t5_cnt_sat", oDISCARD_CNT, 8'd255);
        check("t5_still_pops", oQ_RD_REQ, 1'b1);
        idle();
        tick();
        check("t5_cnt_hold", oDISCARD_CNT, 8'd255);

        // 6: async reset during a bus stall
        beat(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        iBUS_BUSY = 1'b1;
        beat(1'b0, 1'b1, 1'b1, 32'hC0DE_0001);
        tick();
        beat(1'b0, 1'b1, 1'b1, 32'hC0DE_0002);
        check("t6_pre_orphan", oERR_ORPHAN, 1'b1);
        check("t6_pre_bus_valid", oBUS_VALID, 1'b1);
        check("t6_pre_stall", oMEM_BUSY, 1'b1);
        #2;
        inRESET = 1'b0;
        #1;
        check("t6_bus_valid", oBUS_VALID, 1'b0);
        check("t6_disp_valid", oDISP_VALID, 1'b0);
        check("t6_orphan", oERR_ORPHAN, 1'b0);
        check("t6_cnt", oDISCARD_CNT, 8'd0);
        check("t6_no_pop", oQ_RD_REQ, 1'b0);
        tick();
        check("t6_no_pop_held", oQ_RD_REQ, 1'b0);
        idle();
        iBUS_BUSY = 1'b0;
        inRESET   = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_arbiter_response_router.md
Name: vga_arbiter_response_router

Overview:
- Consumer (read side) of the VGA arbiter's request-tag matching queue.
- Pops one tag per SDRAM read-data beat and steers the beat to the originating client: display prefetch (flag 0) or CPU bus (flag 1).
- Drains tags that the queue has invalidated by flush, and discards the matching data, so tag/data alignment survives flushes.
- Sits between the SDRAM controller read-return path and the two arbiter clients.

Parameters:
- DW, 32, read data width.
- FN, 1, tag width; must match the matching queue. Only values 0 and 1 are meaningful.
- CW, 8, width of the saturating discard counter.

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  reset, asynchronous, active-low
- iRESET_SYNC  in  1  synchronous reset: same effect as inRESET
- iFLASH  in  1  flush strobe, shared with the matching queue
- oQ_RD_REQ  out  1  pop request to the matching queue
- iQ_RD_VALID  in  1  head tag valid (low means the entry was flushed)
- iQ_RD_FLAG  in  FN  head tag
- iQ_RD_EMPTY  in  1  matching queue empty
- iMEM_VALID  in  1  read-data beat present
- iMEM_DATA  in  DW  read data
- oMEM_BUSY  out  1  backpressure to the SDRAM return path
- oDISP_VALID  out  1  display data valid
- oDISP_DATA  out  DW  display data
- iDISP_BUSY  in  1  display cannot accept
- oBUS_VALID  out  1  bus data valid
- oBUS_DATA  out  DW  bus data
- iBUS_BUSY  in  1  bus cannot accept
- oERR_ORPHAN  out  1  sticky: a beat arrived with no tag
- oDISCARD_CNT  out  CW  count of flushed beats discarded, saturating

Behaviour:
- Reset (inRESET low or iRESET_SYNC high):
  - oDISP_VALID, oBUS_VALID, oERR_ORPHAN = 0; oDISCARD_CNT = 0.
  - Data registers are don't-care.
- Slot model: each client has a one-entry output slot.
  - A slot is free when its valid is 0, or when its client drains it this cycle (valid && !busy).
  - A client transfer occurs on any cycle with oX_VALID && !iX_BUSY.
  - Data is held stable while busy.
- Beat classification is combinational, on the cycle iMEM_VALID is high:
  - ORPHAN: iQ_RD_EMPTY = 1.
  - STALE: !iQ_RD_EMPTY && (!iQ_RD_VALID || iFLASH).
  - ROUTE: !iQ_RD_EMPTY && iQ_RD_VALID && !iFLASH; target slot = iQ_RD_FLAG[0].
- oMEM_BUSY = iMEM_VALID && ROUTE && target slot not free. It is 0 for ORPHAN and STALE.
- Accept = iMEM_VALID && !oMEM_BUSY.
- oQ_RD_REQ = Accept && !iQ_RD_EMPTY. Exactly one pop per accepted tagged beat, including STALE.
- ROUTE accept:
  - Target slot loads data; valid = 1 in the next cycle. Latency is 1 cycle from accept to oX_VALID.
  - Back-to-back beats to the same client sustain 1 beat/cycle while that client is not busy.
- STALE accept: data dropped; oDISCARD_CNT increments and saturates at all-ones.
- ORPHAN: data dropped, no pop; oERR_ORPHAN set, held until reset.
- iFLASH high: both slot valids clear in the next cycle.
  - A ROUTE load cannot coincide with a flush, because iFLASH forces STALE classification.
  - A client transfer completing on the flush cycle still counts as a transfer.
- No width arithmetic beyond the CW-bit saturating increment. Flag bits above [0] are ignored.
- The router never pops while the queue is empty, and never pops twice per cycle.

Decomposition:
- Package vga_arbiter_pkg:
  - VGA_ARB_FLAG_DISP = 1'b0, VGA_ARB_FLAG_BUS = 1'b1.
  - Default DW.
  - Shared with the request-side arbiter and the matching queue instantiation.
- Sub-module vga_arbiter_response_slot:
  - One-entry valid/data register with load, busy, flush and sync-reset inputs.
  - Exposes a free output.
  - Instantiated twice.

Test Plan:
1. Tags 0,1,0 queued; beats A,B,C on consecutive cycles with both clients idle -> oDISP_VALID with A at cycle+1 and C at cycle+3; oBUS_VALID with B at cycle+2; three pops; oMEM_BUSY never high.
2. Tag 0 twice; iDISP_BUSY=1; beats A,B -> A loads; oMEM_BUSY=1 while B waits and B is not popped; deassert busy -> A transfers, B loads the same cycle and is visible the next cycle.
3. Two tags queued, then iFLASH pulse (head iQ_RD_VALID=0); two beats -> two pops, no client valid, oDISCARD_CNT=2, oMEM_BUSY=0.
4. Beat with iQ_RD_EMPTY=1 -> no pop, oERR_ORPHAN=1 and held until iRESET_SYNC pulse, then 0.
5. 300 stale beats with CW=8 -> oDISCARD_CNT saturates at 255.
6. Slot full (iBUS_BUSY=1) then inRESET asserted mid-stall -> all valids, oERR_ORPHAN and oDISCARD_CNT = 0 immediately; oQ_RD_REQ=0.
